// File: rtl/ble_adv_hop_scheduler.sv
// BLE advertising-channel hop scheduler.
// Walks the enabled advertising channels (37/38/39): retunes the RF front-end,
// flushes and gates the packet decoder, dwells per channel, holds the channel
// while a packet is being captured, and reports per-packet events and
// saturating statistics.
module ble_adv_hop_scheduler #(
  parameter int DWELL_W         = 24,
  parameter int ACK_TIMEOUT     = 256,
  parameter int CAPTURE_TIMEOUT = 4096,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_enable,
  input  logic [2:0]         cfg_chan_mask,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               rf_tune_ack,
  input  logic               dec_sync,
  input  logic               dec_packet_valid,
  input  logic               dec_crc_error,
  output logic [5:0]         rf_chan,
  output logic               rf_tune,
  output logic               dec_enable,
  output logic               dec_flush,
  output logic               evt_valid,
  output logic [5:0]         evt_chan,
  output logic               evt_crc_err,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   crc_err_cnt,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic [7:0]         debug_state
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int CW = $clog2(CAPTURE_TIMEOUT + 1);
  localparam logic [AW-1:0]      ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0]      CAP_LAST = CW'(CAPTURE_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0] DWELL_1  = DWELL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TUNE     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_LISTEN   = 3'd3,
    S_CAPTURE  = 3'd4,
    S_HOP      = 3'd5
  } state_t;

  state_t             state;
  logic [AW-1:0]      ack_cnt;
  logic [CW-1:0]      cap_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  // Channel index 0..2 stands for 37..39; wraps 2 -> 0.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First enabled index at or after 'start' in cyclic order.
  function automatic logic [1:0] pick(input logic [1:0] start, input logic [2:0] mask);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(start);
    c2 = inc3(c1);
    if (mask[start])   return start;
    else if (mask[c1]) return c1;
    else               return c2;
  endfunction

  function automatic logic [5:0] chan_of(input logic [1:0] idx);
    return 6'd37 + {4'd0, idx};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // rf_chan is always 37..39, so its low two bits minus one give the index.
  logic [1:0] cur_idx, idx_incl, idx_excl;
  assign cur_idx  = rf_chan[1:0] - 2'd1;
  assign idx_incl = pick(cur_idx, cfg_chan_mask);
  assign idx_excl = pick(inc3(cur_idx), cfg_chan_mask);

  assign debug_state = {5'd0, state};

  // Scheduler FSM with all outputs and statistics registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ack_cnt     <= '0;
      cap_cnt     <= '0;
      dwell_cnt   <= '0;
      rf_chan     <= 6'd37;
      rf_tune     <= 1'b0;
      dec_enable  <= 1'b0;
      dec_flush   <= 1'b0;
      evt_valid   <= 1'b0;
      evt_chan    <= 6'd37;
      evt_crc_err <= 1'b0;
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      rf_tune   <= 1'b0;
      dec_flush <= 1'b0;
      evt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          dec_enable <= 1'b0;
          if (cfg_enable && (cfg_chan_mask != 3'b000)) begin
            rf_chan   <= chan_of(idx_incl);
            rf_tune   <= 1'b1;
            dec_flush <= 1'b1;
            state     <= S_TUNE;
          end
        end
        S_TUNE: begin
          dec_enable <= 1'b0;
          ack_cnt    <= '0;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!cfg_enable) begin
            state <= S_IDLE;
          end else if (rf_tune_ack) begin
            dwell_cnt  <= (cfg_dwell == '0) ? DWELL_1 : cfg_dwell;
            dec_enable <= 1'b1;
            state      <= S_LISTEN;
          end else if (ack_cnt == ACK_LAST) begin
            timeout_cnt <= sat_inc(timeout_cnt);
            state       <= S_HOP;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_LISTEN: begin
          if (!cfg_enable) begin
            dec_enable <= 1'b0;
            state      <= S_IDLE;
          end else if (dec_sync) begin
            // Dwell is frozen for the whole capture.
            cap_cnt <= '0;
            state   <= S_CAPTURE;
          end else if (dwell_cnt <= DWELL_1) begin
            dwell_cnt  <= '0;
            dec_enable <= 1'b0;
            state      <= S_HOP;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_1;
          end
        end
        S_CAPTURE: begin
          if (dec_crc_error || dec_packet_valid || (cap_cnt == CAP_LAST)) begin
            if (dec_crc_error) begin
              crc_err_cnt <= sat_inc(crc_err_cnt);
              evt_valid   <= 1'b1;
              evt_crc_err <= 1'b1;
              evt_chan    <= rf_chan;
            end else if (dec_packet_valid) begin
              good_cnt    <= sat_inc(good_cnt);
              evt_valid   <= 1'b1;
              evt_crc_err <= 1'b0;
              evt_chan    <= rf_chan;
            end else begin
              timeout_cnt <= sat_inc(timeout_cnt);
            end
            // cfg_enable is only honoured once the packet has resolved.
            if (cfg_enable && (dwell_cnt != '0)) begin
              state <= S_LISTEN;
            end else begin
              dec_enable <= 1'b0;
              state      <= cfg_enable ? S_HOP : S_IDLE;
            end
          end else begin
            cap_cnt <= cap_cnt + 1'b1;
          end
        end
        S_HOP: begin
          dec_enable <= 1'b0;
          if (!cfg_enable || (cfg_chan_mask == 3'b000)) begin
            state <= S_IDLE;
          end else begin
            // A single enabled channel reselects itself and still retunes.
            rf_chan   <= chan_of(idx_excl);
            rf_tune   <= 1'b1;
            dec_flush <= 1'b1;
            state     <= S_TUNE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_adv_hop_scheduler.sv
// Bench for ble_adv_hop_scheduler: packet vector table plus hand-written
// sequences for rotation, ack timeout, capture timeout, mask changes,
// enable drop during capture, reset mid-capture and counter saturation.
module tb_ble_adv_hop_scheduler;

  localparam int DWELL_W = 24;
  localparam int ACK_TO  = 16;
  localparam int CAP_TO  = 40;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_enable = 1'b0;
  logic [2:0]         cfg_chan_mask = 3'b000;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               rf_tune_ack = 1'b0;
  logic               dec_sync = 1'b0;
  logic               dec_packet_valid = 1'b0;
  logic               dec_crc_error = 1'b0;
  logic [5:0]         rf_chan;
  logic               rf_tune;
  logic               dec_enable;
  logic               dec_flush;
  logic               evt_valid;
  logic [5:0]         evt_chan;
  logic               evt_crc_err;
  logic [CNT_W-1:0]   good_cnt;
  logic [CNT_W-1:0]   crc_err_cnt;
  logic [CNT_W-1:0]   timeout_cnt;
  logic [7:0]         debug_state;

  ble_adv_hop_scheduler #(
    .DWELL_W(DWELL_W), .ACK_TIMEOUT(ACK_TO), .CAPTURE_TIMEOUT(CAP_TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_chan_mask(cfg_chan_mask),
    .cfg_dwell(cfg_dwell), .rf_tune_ack(rf_tune_ack), .dec_sync(dec_sync),
    .dec_packet_valid(dec_packet_valid), .dec_crc_error(dec_crc_error),
    .rf_chan(rf_chan), .rf_tune(rf_tune), .dec_enable(dec_enable), .dec_flush(dec_flush),
    .evt_valid(evt_valid), .evt_chan(evt_chan), .evt_crc_err(evt_crc_err),
    .good_cnt(good_cnt), .crc_err_cnt(crc_err_cnt), .timeout_cnt(timeout_cnt),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mask;
    logic       good;
    logic       bad;
    logic [5:0] exp_chan;
    logic       exp_crc;
    int         exp_good;
    int         exp_crc_cnt;
  } vec_t;

  vec_t       vecs [4];
  logic [6:0] sb_q [$];
  logic [6:0] sb_exp;
  int         checks = 0;
  int         errors = 0;
  logic       auto_ack = 1'b0;
  int         ack_dly = 0;
  int         tunes [8];
  int         tune_cyc [8];
  int         ntune;
  int         nruns;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Front-end model: acks 4 cycles after each retune request when enabled.
  initial forever begin
    @(negedge clk);
    rf_tune_ack = 1'b0;
    if (rst) ack_dly = 0;
    else begin
      if (ack_dly > 0) begin
        ack_dly--;
        if (ack_dly == 0) rf_tune_ack = 1'b1;
      end
      if (auto_ack && rf_tune === 1'b1) ack_dly = 4;
    end
  end

  // Event scoreboard: every evt_valid must match the oldest expected event.
  initial forever begin
    @(negedge clk);
    if (evt_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected actual chan %0d crc %0d required no event", evt_chan, evt_crc_err);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("evt_chan_crc", {25'd0, evt_crc_err, evt_chan}, {25'd0, sb_exp});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_chan_mask = 3'b000;
    cfg_dwell = '0;
    dec_sync = 1'b0;
    dec_packet_valid = 1'b0;
    dec_crc_error = 1'b0;
    auto_ack = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_den(input int budget);
    for (int i = 0; i < budget && dec_enable !== 1'b1; i++) tick(1);
    chk("dec_enable_rise", {31'd0, dec_enable}, 1);
  endtask

  // Follows retune pulses; optionally checks each dec_enable run length.
  task automatic watch_tunes(input int want, input int budget, input int exp_run);
    int   run;
    logic prev;
    run = 0;
    prev = 1'b0;
    ntune = 0;
    nruns = 0;
    for (int i = 0; i < budget && ntune < want; i++) begin
      tick(1);
      if (rf_tune === 1'b1) begin
        chk("flush_with_tune", {31'd0, dec_flush}, 1);
        chk("tune_one_cycle", {31'd0, prev}, 0);
        tunes[ntune] = int'(rf_chan);
        tune_cyc[ntune] = i;
        ntune++;
      end
      prev = rf_tune;
      if (exp_run > 0) begin
        if (dec_enable === 1'b1) run++;
        else if (run > 0) begin
          chk("dwell_cycles", run, exp_run);
          nruns++;
          run = 0;
        end
      end
    end
    chk("tune_count", ntune, want);
  endtask

  initial begin
    vecs[0] = '{3'b111, 1'b1, 1'b0, 6'd37, 1'b0, 1, 0};
    vecs[1] = '{3'b110, 1'b0, 1'b1, 6'd38, 1'b1, 0, 1};
    vecs[2] = '{3'b100, 1'b1, 1'b1, 6'd39, 1'b1, 0, 1};
    vecs[3] = '{3'b010, 1'b1, 1'b0, 6'd38, 1'b0, 1, 0};

    // Reset with every input active: reset values must hold.
    rst = 1'b1;
    cfg_enable = 1'b1;
    cfg_chan_mask = 3'b111;
    dec_sync = 1'b1;
    dec_packet_valid = 1'b1;
    dec_crc_error = 1'b1;
    tick(3);
    chk("rst_rf_chan", rf_chan, 37);
    chk("rst_rf_tune", rf_tune, 0);
    chk("rst_dec_flush", dec_flush, 0);
    chk("rst_dec_enable", dec_enable, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_chan", evt_chan, 37);
    chk("rst_evt_crc", evt_crc_err, 0);
    chk("rst_good", good_cnt, 0);
    chk("rst_crc", crc_err_cnt, 0);
    chk("rst_timeout", timeout_cnt, 0);
    chk("rst_state", debug_state, 0);
    do_reset();
    chk("idle_after_rst", debug_state, 0);

    // Packet vector table.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      auto_ack = 1'b1;
      cfg_chan_mask = vecs[v].mask;
      cfg_dwell = 50;
      cfg_enable = 1'b1;
      wait_den(50);
      tick(3);
      dec_sync = 1'b1;
      tick(2);
      dec_sync = 1'b0;
      dec_packet_valid = vecs[v].good;
      dec_crc_error = vecs[v].bad;
      sb_q.push_back({vecs[v].exp_crc, vecs[v].exp_chan});
      tick(1);
      dec_packet_valid = 1'b0;
      dec_crc_error = 1'b0;
      tick(2);
      chk("tbl_good_cnt", good_cnt, vecs[v].exp_good);
      chk("tbl_crc_cnt", crc_err_cnt, vecs[v].exp_crc_cnt);
    end

    // Rotation 37,38,39,37 with 100-cycle dwell.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b111;
    cfg_dwell = 100;
    cfg_enable = 1'b1;
    watch_tunes(4, 1000, 100);
    chk("rot_ch0", tunes[0], 37);
    chk("rot_ch1", tunes[1], 38);
    chk("rot_ch2", tunes[2], 39);
    chk("rot_ch3", tunes[3], 37);
    chk("rot_runs", nruns, 3);

    // Capture on ch38 at dwell 60, resume remaining 60 cycles, hop to 39.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b111;
    cfg_dwell = 100;
    cfg_enable = 1'b1;
    watch_tunes(2, 400, 100);
    chk("cap_on_38", tunes[1], 38);
    wait_den(50);
    tick(40);
    dec_sync = 1'b1;
    tick(30);
    dec_sync = 1'b0;
    dec_packet_valid = 1'b1;
    sb_q.push_back({1'b0, 6'd38});
    tick(1);
    dec_packet_valid = 1'b0;
    begin
      int run;
      run = 0;
      for (int i = 0; i < 200 && dec_enable === 1'b1; i++) begin
        run++;
        tick(1);
      end
      chk("resume_dwell", run, 60);
    end
    chk("cap_good_cnt", good_cnt, 1);
    watch_tunes(1, 20, 0);
    chk("cap_hop_39", tunes[0], 39);

    // No ack ever: timeouts every ACK_TO+2 cycles, channels still rotate.
    do_reset();
    cfg_chan_mask = 3'b111;
    cfg_dwell = 10;
    cfg_enable = 1'b1;
    watch_tunes(3, 200, 0);
    chk("noack_ch0", tunes[0], 37);
    chk("noack_ch1", tunes[1], 38);
    chk("noack_ch2", tunes[2], 39);
    chk("noack_period0", tune_cyc[1] - tune_cyc[0], ACK_TO + 2);
    chk("noack_period1", tune_cyc[2] - tune_cyc[1], ACK_TO + 2);
    chk("noack_timeouts", timeout_cnt, 2);

    // Capture timeout boundary: no result for CAP_TO cycles.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b001;
    cfg_dwell = 100;
    cfg_enable = 1'b1;
    wait_den(50);
    dec_sync = 1'b1;
    tick(1);
    dec_sync = 1'b0;
    tick(CAP_TO - 1);
    chk("captmo_before_cnt", timeout_cnt, 0);
    chk("captmo_before_state", debug_state, 4);
    tick(1);
    chk("captmo_after_cnt", timeout_cnt, 1);
    chk("captmo_after_state", debug_state, 3);

    // Single channel 39: every hop retunes and flushes; mask 0 then idles.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b100;
    cfg_dwell = 20;
    cfg_enable = 1'b1;
    watch_tunes(3, 300, 20);
    chk("single_ch0", tunes[0], 39);
    chk("single_ch1", tunes[1], 39);
    chk("single_ch2", tunes[2], 39);
    wait_den(20);
    tick(5);
    cfg_chan_mask = 3'b000;
    begin
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < 100 && debug_state !== 8'd0; i++) begin
        tick(1);
        if (rf_tune === 1'b1) saw = 1'b1;
      end
      chk("mask0_idle", debug_state, 0);
      chk("mask0_no_retune", {31'd0, saw}, 0);
    end
    chk("mask0_den", dec_enable, 0);
    tick(5);
    chk("mask0_stay_idle", debug_state, 0);

    // cfg_enable dropped mid-capture: packet completes, then IDLE.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b111;
    cfg_dwell = 50;
    cfg_enable = 1'b1;
    wait_den(50);
    tick(2);
    dec_sync = 1'b1;
    tick(1);
    cfg_enable = 1'b0;
    tick(3);
    chk("dis_still_capture", debug_state, 4);
    chk("dis_den_held", dec_enable, 1);
    dec_sync = 1'b0;
    dec_packet_valid = 1'b1;
    sb_q.push_back({1'b0, 6'd37});
    tick(1);
    dec_packet_valid = 1'b0;
    chk("dis_idle", debug_state, 0);
    chk("dis_den_low", dec_enable, 0);
    chk("dis_good", good_cnt, 1);

    // Reset mid-capture discards the packet: no event, no count.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b111;
    cfg_dwell = 50;
    cfg_enable = 1'b1;
    wait_den(50);
    dec_sync = 1'b1;
    tick(2);
    chk("rstcap_capture", debug_state, 4);
    rst = 1'b1;
    cfg_enable = 1'b0;
    dec_sync = 1'b0;
    dec_packet_valid = 1'b1;
    tick(1);
    dec_packet_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("rstcap_good", good_cnt, 0);
    chk("rstcap_state", debug_state, 0);

    // Saturation: 17 good packets into a 4-bit counter.
    do_reset();
    auto_ack = 1'b1;
    cfg_chan_mask = 3'b001;
    cfg_dwell = 1000;
    cfg_enable = 1'b1;
    wait_den(50);
    for (int p = 0; p < 17; p++) begin
      dec_sync = 1'b1;
      tick(1);
      dec_sync = 1'b0;
      dec_packet_valid = 1'b1;
      sb_q.push_back({1'b0, 6'd37});
      tick(1);
      dec_packet_valid = 1'b0;
    end
    tick(2);
    chk("sat_good", good_cnt, 15);
    chk("sat_crc", crc_err_cnt, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
